// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the IF-stage PC sequencer: bus range, jump-mux select
// encodings, FSM state encodings and default reset/trap addresses.
package pc_sequencer_pkg;

    localparam int PC_WIDTH_DEF = 16;
    localparam int PC_BUS_MSB   = PC_WIDTH_DEF - 1;

    localparam logic [PC_BUS_MSB:0] RESET_PC_DEF    = 16'h0000;
    localparam logic [PC_BUS_MSB:0] TRAP_VECTOR_DEF = 16'h0004;

    localparam logic PC_JUMP_ENABLE  = 1'b1;
    localparam logic PC_JUMP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_MEM = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_redirect_latch.sv
// Holds a taken redirect that arrived before its fetch was acknowledged; a newer
// redirect overwrites the held target and a clear discards it.
module pc_redirect_latch #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set,
    input  logic [PC_WIDTH-1:0] set_target,
    input  logic                clear,
    output logic                pend_valid,
    output logic [PC_WIDTH-1:0] pend_target
);

    // Pending-redirect register: clear outranks set, set overwrites any held target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (clear) begin
            pend_valid  <= 1'b0;
        end else if (set) begin
            pend_valid  <= 1'b1;
            pend_target <= set_target;
        end else begin
            pend_valid  <= pend_valid;
            pend_target <= pend_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC sequencer: owns PC, arbitrates fetch against the data side and
// generates redirect flushes. Optional trap entry is enabled by PC_SEQ_TRAP_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                  PC_STEP  = 1
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                mem_busy,
    input  logic                fetch_ack,
`ifdef PC_SEQ_TRAP_EN
    input  logic                trap_req,
    output logic [PC_WIDTH-1:0] epc,
`endif
    output logic                fetch_req,
    output logic [PC_WIDTH-1:0] fetch_addr,
    output logic                inst_valid,
    output logic                flush_if,
    output logic                PC_jump_op,
    output logic [PC_WIDTH-1:0] PC_jump,
    output logic [PC_WIDTH-1:0] PC_add,
    output logic [PC_WIDTH-1:0] PC
);

    localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(PC_STEP);

    seq_state_e          state_r;
    seq_state_e          state_nxt_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_nxt_s;
    logic [PC_WIDTH-1:0] pc_add_s;
    logic                inst_valid_r;
    logic                inst_valid_nxt_s;
    logic                fetch_req_s;
    logic                ack_s;
    logic                redirect_now_s;
    logic [PC_WIDTH-1:0] target_s;
    logic [PC_WIDTH-1:0] jump_mux_s;
    logic                flush_s;
    logic                jump_op_s;
    logic                pend_set_s;
    logic                pend_clr_s;
    logic                pend_valid_s;
    logic [PC_WIDTH-1:0] pend_target_s;
    logic                trap_s;

    pc_redirect_latch #(
        .PC_WIDTH (PC_WIDTH)
    ) u_redirect_latch (
        .clk         (clk),
        .rst         (rst),
        .set         (pend_set_s),
        .set_target  (jump_target),
        .clear       (pend_clr_s),
        .pend_valid  (pend_valid_s),
        .pend_target (pend_target_s)
    );

`ifdef PC_SEQ_TRAP_EN
    assign trap_s = trap_req;
`else
    assign trap_s = 1'b0;
`endif

    assign pc_add_s = pc_r + STEP_V;

    // FSM next state and port arbitration: data side owns the port whenever mem_busy
    always_comb begin
        state_nxt_s = state_r;
        fetch_req_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_req_s = !mem_busy;
                if (mem_busy) begin
                    state_nxt_s = ST_WAIT_MEM;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_WAIT_MEM: begin
                fetch_req_s = !mem_busy;
                if (mem_busy) begin
                    state_nxt_s = ST_WAIT_MEM;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // PC update priority: trap, redirect, deferred redirect, stall, sequential
    always_comb begin
        ack_s            = fetch_ack && fetch_req_s;
        redirect_now_s   = jump_valid || pend_valid_s;
        pc_nxt_s         = pc_r;
        inst_valid_nxt_s = 1'b0;
        flush_s          = 1'b0;
        jump_op_s        = PC_JUMP_DISABLE;
        pend_set_s       = 1'b0;
        pend_clr_s       = 1'b0;
        if (jump_valid) begin
            target_s = jump_target;
        end else begin
            target_s = pend_target_s;
        end
        jump_mux_s = target_s;

        if (trap_s) begin
`ifdef PC_SEQ_TRAP_EN
            pc_nxt_s   = TRAP_VECTOR;
            jump_mux_s = TRAP_VECTOR;
`else
            pc_nxt_s   = pc_r;
`endif
            pend_clr_s = 1'b1;
            flush_s    = 1'b1;
            jump_op_s  = PC_JUMP_ENABLE;
        end else if (redirect_now_s && (ack_s || (state_r == ST_WAIT_MEM))) begin
            pc_nxt_s   = target_s;
            pend_clr_s = 1'b1;
            flush_s    = 1'b1;
            jump_op_s  = PC_JUMP_ENABLE;
        end else if (jump_valid && (state_r == ST_FETCH)) begin
            // Fetch in flight at the old PC: remember the target, kill the stale word
            pend_set_s = 1'b1;
            flush_s    = 1'b1;
        end else if (stall) begin
            pc_nxt_s = pc_r;
        end else if (ack_s) begin
            pc_nxt_s         = pc_add_s;
            inst_valid_nxt_s = 1'b1;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            inst_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            inst_valid_r <= inst_valid_nxt_s;
        end
    end

`ifdef PC_SEQ_TRAP_EN
    // Exception PC captured on trap entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= '0;
        end else if (trap_s) begin
            epc <= pc_r;
        end else begin
            epc <= epc;
        end
    end
`endif

    assign fetch_req  = fetch_req_s;
    assign fetch_addr = pc_r;
    assign PC         = pc_r;
    assign PC_add     = pc_add_s;
    assign PC_jump    = jump_mux_s;
    assign PC_jump_op = jump_op_s;
    assign flush_if   = flush_s;
    assign inst_valid = inst_valid_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer; define PC_SEQ_TRAP_EN to cover trap entry.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        mem_busy = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        inst_valid;
    logic        flush_if;
    logic        PC_jump_op;
    logic [15:0] PC_jump;
    logic [15:0] PC_add;
    logic [15:0] PC;
`ifdef PC_SEQ_TRAP_EN
    logic        trap_req = 1'b0;
    logic [15:0] epc;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .mem_busy    (mem_busy),
        .fetch_ack   (fetch_ack),
`ifdef PC_SEQ_TRAP_EN
        .trap_req    (trap_req),
        .epc         (epc),
`endif
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .inst_valid  (inst_valid),
        .flush_if    (flush_if),
        .PC_jump_op  (PC_jump_op),
        .PC_jump     (PC_jump),
        .PC_add      (PC_add),
        .PC          (PC)
    );

    typedef struct {
        bit        req;
        bit [15:0] pc;
        bit        iv;
        bit        fl;
        bit        op;
        bit [15:0] tgt;
        bit [15:0] add;
        bit [15:0] epc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: booted/port-lost flags, pending target (-1 = none), PC as integer
    bit m_booted;
    bit m_lost;
    bit m_iv;
    int m_pend;
    int m_pc;
    int m_epc;

    task automatic model_reset();
        m_booted = 1'b0;
        m_lost   = 1'b0;
        m_iv     = 1'b0;
        m_pend   = -1;
        m_pc     = 0;
        m_epc    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #4;
        rst = 1'b1;
        stall = 1'b0; jump_valid = 1'b0; jump_target = 16'h0000;
        mem_busy = 1'b0; fetch_ack = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        trap_req = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycle(input bit st, input bit jv, input bit [15:0] jt,
                         input bit mb, input bit ack, input bit tr);
        exp_t e;
        bit   tre, req, ackd, redir, apply, latch;
        int   tgt, n_pc;
        @(negedge clk);
        #1;
        stall = st; jump_valid = jv; jump_target = jt; mem_busy = mb; fetch_ack = ack;
`ifdef PC_SEQ_TRAP_EN
        trap_req = tr;
        tre = tr;
`else
        tre = 1'b0;
        if (tr) tre = 1'b0;
`endif
        req   = m_booted && !mb;
        ackd  = ack && req;
        redir = jv || (m_pend >= 0);
        tgt   = jv ? int'(jt) : m_pend;
        apply = !tre && redir && (ackd || (m_booted && m_lost));
        latch = !tre && !apply && jv && m_booted && !m_lost;

        e.req = req;
        e.pc  = 16'(m_pc);
        e.iv  = m_iv;
        e.fl  = tre || apply || latch;
        e.op  = tre || apply;
        e.tgt = tre ? 16'h0004 : 16'(tgt);
        e.add = 16'((m_pc + 1) % 65536);
        e.epc = 16'(m_epc);
        sb.push_back(e);

        n_pc = m_pc;
        if (tre) begin
            n_pc = 4; m_epc = m_pc; m_pend = -1;
        end else if (apply) begin
            n_pc = tgt; m_pend = -1;
        end else if (latch) begin
            m_pend = int'(jt);
        end else if (!st && ackd) begin
            n_pc = (m_pc + 1) % 65536;
        end
        m_iv     = ackd && !redir && !st && !tre;
        m_lost   = m_booted ? mb : 1'b0;
        m_booted = 1'b1;
        m_pc     = n_pc;
    endtask

    // Monitor: pops one expected record per cycle once inputs have settled
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                bad = (fetch_req !== e.req) || (fetch_addr !== e.pc) || (PC !== e.pc) ||
                      (inst_valid !== e.iv) || (flush_if !== e.fl) || (PC_jump_op !== e.op) ||
                      (PC_add !== e.add) || (e.op && (PC_jump !== e.tgt));
`ifdef PC_SEQ_TRAP_EN
                if (epc !== e.epc) bad = 1'b1;
`endif
                if (bad) begin
                    miscompares++;
                    $display("FAIL vec%0d: got req=%b pc=%h addr=%h iv=%b fl=%b op=%b jmp=%h add=%h; expected req=%b pc=%h iv=%b fl=%b op=%b jmp=%h add=%h epc=%h",
                             vectors, fetch_req, PC, fetch_addr, inst_valid, flush_if, PC_jump_op,
                             PC_jump, PC_add, e.req, e.pc, e.iv, e.fl, e.op, e.tgt, e.add, e.epc);
                end
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        // Boot then straight-line fetch: 0000, 0001, 0002
        repeat (4) cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Redirect to 0010, then taken jump to 0040 with ack
        cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Data side holds the port for three cycles at 0005
        cycle(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Two unacknowledged jumps, the later target wins
        cycle(1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0090, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Jump during stall, then stall alone
        cycle(1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Wrap from FFFF
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Trap at 0020 (no effect unless the feature is built in)
        cycle(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Reset with a redirect pending
        cycle(1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Randomised traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ((i % 200) == 199) do_reset();
            cycle(($urandom % 5) == 0, ($urandom % 6) == 0, 16'($urandom),
                  ($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 25) == 0);
        end
        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
